// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// counter_seq_ctrl : interval sequencer driving a 4-bit loadable up-counter
// Rev 1.0
// ============================================================================
module counter_seq_ctrl #(
    parameter int CNT_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] start_val,
    input  logic [CNT_W-1:0] end_val,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] count_i,
    output logic             load,
    output logic [CNT_W-1:0] load_data,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] start_q;
    logic [CNT_W-1:0] end_q;
    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] iter_q;
    logic             busy_q;
    logic             done_q;

    logic match;
    logic cont;
    logic last;

    // A zero repeat count means the periods continue until stop.
    always_comb begin
        match     = (state_q == S_RUN) && (count_i == end_q);
        cont      = (rep_q == '0);
        last      = !cont && (iter_q == REP_W'(1));
        load      = (state_q == S_LOAD) || (match && !last);
        load_data = load ? start_q : '0;
        tick      = match;
    end

    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            start_q <= '0;
            end_q   <= '0;
            rep_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        start_q <= start_val;
                        end_q   <= end_val;
                        rep_q   <= repeat_cnt;
                        iter_q  <= repeat_cnt;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // stop ends the sequence without done, even on a period end.
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (match) begin
                        if (last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (!cont) begin
                            iter_q <= iter_q - REP_W'(1);
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Programmable interval sequencer for the team's 4-bit loadable up-counter.
- Drives the counter's load / load_data inputs and watches its count output.
- Each period runs from a start value to an end value; the period repeats a programmed number of times, or continuously.
- Emits a one-cycle tick at each period end and a done pulse after the final period.

Parameters:
- CNT_W, 4, width of the counter value and of start/end configuration.
- REP_W, 4, width of the repeat count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset. It is the same net as the counter's reset_n.
- start  input  1  launch request. Sampled in IDLE only; ignored while busy.
- stop  input  1  abort request. Honoured in LOAD/RUN.
- start_val  input  CNT_W  first count of each period. Latched on accepted start.
- end_val  input  CNT_W  last count of each period. Latched on accepted start.
- repeat_cnt  input  REP_W  number of periods. 0 = continuous until stop. Latched on accepted start.
- count_i  input  CNT_W  counter's current count.
- load  output  1  to counter load. Combinational from registered state and count_i.
- load_data  output  CNT_W  to counter load_data. Equals latched start_val whenever load=1, else 0.
- tick  output  1  period-end strobe. Combinational.
- busy  output  1  high in LOAD and RUN. Registered.
- done  output  1  one-cycle pulse after the final period. Registered.

Behaviour:
- Reset (async, any state): state=IDLE; latched config=0; iteration counter=0; load=0, load_data=0, tick=0, busy=0, done=0.
- States: IDLE, LOAD, RUN.
- IDLE:
  - start=1 → LOAD at next edge; latches start_val/end_val/repeat_cnt; iter_left = repeat_cnt.
  - Outputs low; done may be high for its pulse cycle only.
- LOAD:
  - load=1, load_data=start_val for exactly one cycle.
  - Next edge: counter holds start_val; state → RUN.
- RUN: match = (count_i == latched end_val).
  - On match, tick=1.
  - If continuous (repeat_cnt=0) or iter_left>1: load=1, load_data=start_val; decrement iter_left (no decrement when continuous); stay in RUN.
  - If iter_left==1: load=0; at the edge go to IDLE and set done=1 for one cycle.
  - No match: load=0, tick=0.
- Period length = ((end_val - start_val) mod 2^CNT_W) + 1 cycles.
  - Wrap-around through 15→0 is legal: start=14, end=1 gives a period of 4.
  - start_val==end_val gives a period of 1: tick every RUN cycle.
- stop:
  - In LOAD or RUN: → IDLE at next edge. No done, no further load.
  - If stop coincides with a match, tick still fires that cycle. load (if any) is still driven, but the sequence ends.
  - stop in IDLE has no effect.
  - stop and start together in IDLE: start wins.
- start while busy: ignored; config not relatched.
- Counter free-runs in IDLE; the controller ignores count_i there.
- busy rises on the edge after start is accepted and falls on the edge ending the final period or the stop.
- Latency:
  - start → load: 1 cycle.
  - start → first count=start_val: 2 edges.
  - final tick → done: 1 cycle.
- Reset mid-run: all outputs drop immediately and asynchronously; no done.

Test Plan:
- Reset: assert reset_n=0 mid-RUN → load/tick/busy/done=0 immediately; state IDLE after release; start=0 keeps it idle.
- start_val=3, end_val=6, repeat_cnt=2 → load in cycle 1; count 3,4,5,6 with tick at 6 and load=1, load_data=3; count 3,4,5,6 with tick and load=0; done=1 in the next cycle with busy=0; exactly 2 ticks.
- Wrap: start_val=14, end_val=1, repeat_cnt=1 → count 14,15,0,1; tick at 1; done next cycle.
- Continuous: start_val=5, end_val=5, repeat_cnt=0 → tick and load every RUN cycle; stop after 7 ticks → IDLE next edge, done never asserted.
- start pulsed while busy with different config → ignored; original start/end/repeat complete unchanged.
- stop on the same cycle as a match → tick=1 that cycle, then IDLE, busy=0, done=0.
